muldiv_unit: RTL and testbench

Parametrised iterative multiply/divide unit for the processor's execute stage. It replaces the single-cycle combinational MUL/DIV paths in the ALU with a sequential shift-add multiplier and a restoring divider sharing one accumulator. It supports signed and unsigned operation and writes a double-width HI/LO result. The datapath issues via a start/busy/done handshake and stalls while `busy` is high.

---
 rtl/muldiv_pkg.sv | 26 ++
 rtl/muldiv_signfix.sv | 16 +
 rtl/muldiv_unit.sv | 170 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    : operation select presented on the op port
//   muldiv_state_t : sequencer states of muldiv_unit
//   cnt_width()    : iteration counter width for a given operand width
package muldiv_pkg;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

    // Counter must hold 0..w-1; never narrower than one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate, purely combinational.
//   val : input value
//   neg : when high, res = -val; otherwise res = val
//   res : result, same width as val
// Used both to form operand magnitudes and to restore result signs.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (-val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiplier and restoring
// divider sharing one 2*WIDTH accumulator, one result bit per cycle.
//   clk, rst_b     : rising-edge clock, asynchronous active-low reset
//   start, op, a, b: issue request, operation and operands (IDLE/DONE only)
//   flush          : abort the operation in flight (RUN/FIX)
//   busy           : operation in flight
//   done           : one-cycle completion pulse
//   hi, lo         : product high/low half, or remainder/quotient
//   div_by_zero    : last completed op was a divide by zero
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  muldiv_op_t       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int            CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    muldiv_state_t      state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   dvsr;     // divisor, or multiplicand for multiplies
    logic               is_mult;
    logic               neg_q;    // product / quotient sign
    logic               neg_r;    // remainder sign (follows dividend)

    logic               op_mult;
    logic               op_signed;
    logic               sign_a;
    logic               sign_b;
    logic               issue;
    logic               div_zero;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH-1:0]   rem_sub;
    logic               rem_ge;
    logic [2*WIDTH-1:0] div_next;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign op_mult   = ~op[1];
    assign op_signed = ~op[0];
    assign sign_a    = op_signed & a[WIDTH-1];
    assign sign_b    = op_signed & b[WIDTH-1];
    assign issue     = ((state == IDLE) || (state == DONE)) && start && !flush;
    assign div_zero  = !op_mult && (b == '0);

    // Most-negative operands stay at 2^(WIDTH-1), which is the correct
    // unsigned magnitude, so no special case is needed here.
    muldiv_signfix #(.W(WIDTH)) u_mag_a (.val(a), .neg(sign_a), .res(mag_a));
    muldiv_signfix #(.W(WIDTH)) u_mag_b (.val(b), .neg(sign_b), .res(mag_b));

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit (acc[0]) is set, then shift right with carry.
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, dvsr};
        mul_next = acc[0] ? {mul_sum, acc[WIDTH-1:1]}
                          : {1'b0, acc[2*WIDTH-1:1]};

        // Divide: shift the next dividend bit into the partial remainder and
        // subtract when it fits. The subtraction result is below the divisor,
        // so its low WIDTH bits are exact.
        rem_sh   = acc[2*WIDTH-1:WIDTH-1];
        rem_ge   = (rem_sh >= {1'b0, dvsr});
        rem_sub  = rem_sh[WIDTH-1:0] - dvsr;
        div_next = rem_ge ? {rem_sub, acc[WIDTH-2:0], 1'b1}
                          : {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end

    muldiv_signfix #(.W(2*WIDTH)) u_fix_prod (.val(acc), .neg(neg_q), .res(prod_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(neg_q), .res(quo_fix));
    muldiv_signfix #(.W(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(neg_r), .res(rem_fix));

    // Datapath registers: only meaningful between issue and FIX, so no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            is_mult <= op_mult;
            neg_q   <= sign_a ^ sign_b;
            neg_r   <= sign_a;
            acc     <= op_mult ? {{WIDTH{1'b0}}, mag_b} : {{WIDTH{1'b0}}, mag_a};
            dvsr    <= op_mult ? mag_a : mag_b;
        end else if (state == RUN) begin
            acc     <= is_mult ? mul_next : div_next;
        end
    end

    // Sequencer with registered busy/done/results.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state       <= IDLE;
            cnt         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (issue) begin
                        cnt <= '0;
                        if (div_zero) begin
                            hi          <= a;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                            busy        <= 1'b0;
                            state       <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= FIX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hi          <= is_mult ? prod_fix[2*WIDTH-1:WIDTH] : rem_fix;
                        lo          <= is_mult ? prod_fix[WIDTH-1:0] : quo_fix;
                        div_by_zero <= 1'b0;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        state       <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): directed cases, random
// operations against a plain-arithmetic reference, issue/abort rules.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W   = 32;
    localparam int LAT = W + 2;

    logic         clk;
    logic         rst_b;
    logic         start;
    muldiv_op_t   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_by_zero;

    int           n_chk;
    int           n_err;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
    logic         exp_dz;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .op(op), .a(a), .b(b),
        .flush(flush), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: 64-bit integer arithmetic; SV division truncates toward
    // zero and the remainder follows the dividend, as required.
    function automatic void model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ez);
        longint      sx, sy, ux, uy;
        logic [63:0] pv;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'h0, x});
        uy = longint'({32'h0, y});
        ez = 1'b0;
        pv = '0;
        case (o)
            MD_MULT:  pv = sx * sy;
            MD_MULTU: pv = ux * uy;
            MD_DIV:   if (y != 0) pv = {32'(sx % sy), 32'(sx / sy)};
            default:  if (y != 0) pv = {32'(ux % uy), 32'(ux / uy)};
        endcase
        if ((o == MD_DIV || o == MD_DIVU) && y == 0) begin
            pv = {x, 32'hFFFFFFFF};
            ez = 1'b1;
        end
        eh = pv[63:32];
        el = pv[31:0];
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 9))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h80000000;
            4:       return 32'h7FFFFFFF;
            5:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drive one start pulse; returns at the falling edge of cycle 1 with
    // the operands scrambled (they must no longer matter).
    task automatic issue(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
    endtask

    // Wait for done starting from cycle cyc0; check latency, busy span, results.
    task automatic wait_done(input string tag, input muldiv_op_t o,
                             input logic [31:0] x, input logic [31:0] y, input int cyc0);
        int           cyc = cyc0;
        int           nb  = 0;
        logic [31:0]  eh, el;
        logic         ez;
        model(o, x, y, eh, el, ez);
        if (cyc0 > 1) nb = cyc0 - 1;
        while (!done && cyc < 200) begin
            if (busy) nb++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_latency"}, 64'(cyc), ez ? 64'd1 : 64'(LAT));
        chk({tag, "_busycyc"}, 64'(nb), ez ? 64'd0 : 64'(LAT - 1));
        chk({tag, "_hi"}, {32'h0, hi}, {32'h0, eh});
        chk({tag, "_lo"}, {32'h0, lo}, {32'h0, el});
        chk({tag, "_dz"}, {63'h0, div_by_zero}, {63'h0, ez});
        exp_hi = eh; exp_lo = el; exp_dz = ez;
    endtask

    task automatic run_op(input string tag, input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        wait_done(tag, o, x, y, 1);
        @(negedge clk);
        chk({tag, "_pulse"}, {63'h0, done}, 64'd0);
    endtask

    muldiv_op_t  d_op[6] = '{MD_MULTU, MD_MULT, MD_DIV, MD_DIVU, MD_DIV, MD_DIVU};
    logic [31:0] d_a[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd100, 32'h80000000, 32'd5};
    logic [31:0] d_b[6]  = '{32'hFFFFFFFF, 32'd7, 32'd2, 32'd7, 32'hFFFFFFFF, 32'd0};

    initial begin
        int seen;
        n_chk = 0; n_err = 0;
        exp_hi = '0; exp_lo = '0; exp_dz = 1'b0;
        rst_b = 1'b0; start = 1'b0; flush = 1'b0; op = MD_MULT; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {63'h0, busy}, 64'd0);
        chk("rst_done", {63'h0, done}, 64'd0);
        chk("rst_hi", {32'h0, hi}, 64'd0);
        chk("rst_lo", {32'h0, lo}, 64'd0);
        chk("rst_dz", {63'h0, div_by_zero}, 64'd0);
        rst_b = 1'b1;

        for (int i = 0; i < 6; i++) run_op($sformatf("dir%0d", i), d_op[i], d_a[i], d_b[i]);

        for (int i = 0; i < 40; i++)
            run_op($sformatf("rnd%0d", i), muldiv_op_t'(2'($urandom_range(0, 3))), rnd_val(), rnd_val());

        // start pulsed mid-RUN must be ignored
        issue(MD_DIV, 32'hFFFFFF9C, 32'd7);
        repeat (4) @(negedge clk);
        op = MD_MULTU; a = $urandom; b = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("midstart", MD_DIV, 32'hFFFFFF9C, 32'd7, 6);
        @(negedge clk);
        chk("midstart_idle", {62'h0, busy, done}, 64'd0);

        // back-to-back: start held in the DONE cycle
        issue(MD_MULT, 32'h12345678, 32'hFEDCBA98);
        wait_done("b2b_first", MD_MULT, 32'h12345678, 32'hFEDCBA98, 1);
        op = MD_DIVU; a = 32'hDEADBEEF; b = 32'd1234; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        chk("b2b_busy", {63'h0, busy}, 64'd1);
        wait_done("b2b_second", MD_DIVU, 32'hDEADBEEF, 32'd1234, 1);

        // flush together with start in idle: nothing issues
        @(negedge clk);
        op = MD_MULT; a = 32'd3; b = 32'd3; start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        chk("flushstart_busy", {62'h0, busy, done}, 64'd0);

        // flush at cycle 10 of a MULT: no done, results retained
        issue(MD_MULT, 32'hFFFFFFF0, 32'd99);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_busy", {63'h0, busy}, 64'd0);
        seen = 0;
        repeat (40) begin
            if (done) seen++;
            @(negedge clk);
        end
        chk("flush_nodone", 64'(seen), 64'd0);
        chk("flush_hi", {32'h0, hi}, {32'h0, exp_hi});
        chk("flush_lo", {32'h0, lo}, {32'h0, exp_lo});
        chk("flush_dz", {63'h0, div_by_zero}, {63'h0, exp_dz});
        run_op("post_flush", MD_MULT, 32'hFFFFFFFD, 32'd7);

        // asynchronous reset mid-RUN
        issue(MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (5) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("arst_busy", {63'h0, busy}, 64'd0);
        chk("arst_done", {63'h0, done}, 64'd0);
        chk("arst_hi", {32'h0, hi}, 64'd0);
        chk("arst_lo", {32'h0, lo}, 64'd0);
        chk("arst_dz", {63'h0, div_by_zero}, 64'd0);
        @(negedge clk);
        rst_b = 1'b1;
        run_op("post_reset", MD_DIV, 32'h80000000, 32'hFFFFFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
